// File: rtl/cart_hdr_pkg.sv
// Shared constants and types for the cartridge header scanner.
// Holds the header byte offsets (bank 0, 12-bit page offsets), the
// checksum bias, the scan FSM state type and the checksum helper.
package cart_hdr_pkg;

   localparam logic [11:0] OFS_LOGO    = 12'h104;
   localparam logic [11:0] OFS_CHK_LO  = 12'h134;
   localparam logic [11:0] OFS_CGB     = 12'h142;
   localparam logic [11:0] OFS_SGB_MBC = 12'h146;
   localparam logic [11:0] OFS_ROM_RAM = 12'h148;
   localparam logic [11:0] OFS_LIC     = 12'h14A;
   localparam logic [11:0] OFS_CHK_HI  = 12'h14C;

   // The header checksum subtracts 1 per byte over 0x134..0x14C (25 bytes)
   localparam logic [7:0] HDR_CHK_BIAS = 8'd25;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } scan_state_e;

   function automatic logic [7:0] hdr_chk_calc(input logic [7:0] sum);
      return 8'd0 - sum - HDR_CHK_BIAS;
   endfunction

endpackage

// File: rtl/cart_header_scan_if.sv
// Download bus between the HPS image loader and the header scanner.
//   cart_download : high while a cartridge image is downloading
//   ioctl_wr      : one-cycle write strobe
//   ioctl_addr    : byte address of the 16-bit word (bit 0 always 0)
//   ioctl_dout    : data word, [7:0] even byte, [15:8] odd byte
//   ioctl_wait    : stall request back to the HPS
//   dn_write      : one-tick SDRAM write pulse
interface cart_header_scan_if #(
   parameter int ADDR_W = 25
);
   logic              cart_download;
   logic              ioctl_wr;
   logic [ADDR_W-1:0] ioctl_addr;
   logic [15:0]       ioctl_dout;
   logic              ioctl_wait;
   logic              dn_write;

   modport master (
      output cart_download, ioctl_wr, ioctl_addr, ioctl_dout,
      input  ioctl_wait, dn_write
   );

   modport slave (
      input  cart_download, ioctl_wr, ioctl_addr, ioctl_dout,
      output ioctl_wait, dn_write
   );
endinterface

// File: rtl/cart_logo_probe.sv
// One multicart logo-probe slot. Compares the logo words written at
// BASE + 0x104.. against the bank-0 logo and reports a match once the
// scan finishes.
//   clk_sys, reset : clock, async active-high reset
//   clear          : scan restart, zeroes counter, flag and match
//   latch          : end of scan, registers the match result
//   wr_en          : download write accepted during LOAD
//   addr, dout     : download word address and data
//   logo_ref       : stored bank-0 logo words
//   match          : all logo words seen and equal
module cart_logo_probe
   import cart_hdr_pkg::*;
#(
   parameter int                ADDR_W     = 25,
   parameter int                LOGO_WORDS = 8,
   parameter logic [ADDR_W-1:0] BASE       = '0
) (
   input  logic                        clk_sys,
   input  logic                        reset,
   input  logic                        clear,
   input  logic                        latch,
   input  logic                        wr_en,
   input  logic [ADDR_W-1:0]           addr,
   input  logic [15:0]                 dout,
   input  logic [LOGO_WORDS-1:0][15:0] logo_ref,
   output logic                        match
);

   localparam int IDX_W = (LOGO_WORDS > 1) ? $clog2(LOGO_WORDS) : 1;
   localparam int CNT_W = $clog2(LOGO_WORDS + 1);
   localparam logic [ADDR_W-1:0] WIN_LO = BASE + ADDR_W'(OFS_LOGO);
   localparam logic [ADDR_W-1:0] WIN_HI = WIN_LO + ADDR_W'(2 * (LOGO_WORDS - 1));

   logic [ADDR_W-1:0] rel;
   logic [IDX_W-1:0]  idx;
   logic              hit;
   logic [CNT_W-1:0]  seen;
   logic              mismatch;

   // Word index comes straight from the address so gaps or repeats in
   // the stream cannot skew the comparison.
   assign rel = addr - WIN_LO;
   assign idx = IDX_W'(rel >> 1);
   assign hit = wr_en && (addr >= WIN_LO) && (addr <= WIN_HI);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         seen     <= '0;
         mismatch <= 1'b0;
         match    <= 1'b0;
      end else if (clear) begin
         seen     <= '0;
         mismatch <= 1'b0;
         match    <= 1'b0;
      end else begin
         if (hit) begin
            if (seen != CNT_W'(LOGO_WORDS)) seen <= seen + 1'b1;
            if (dout != logo_ref[idx]) mismatch <= 1'b1;
         end
         if (latch) match <= (seen == CNT_W'(LOGO_WORDS)) && !mismatch;
      end
   end

endmodule

// File: rtl/cart_header_scan.sv
// Cartridge header scanner. Snoops the ROM download stream, extracts the
// header fields, verifies the header checksum, measures the image size,
// probes candidate bank offsets for a repeated logo (multicart detect)
// and paces the download handshake against the CPU clock enable.
//   clk_sys, reset      : clock, async active-high reset
//   ce_cpu, ce_cpu2x    : CPU clock enables (normal / double speed)
//   speed               : 1 = pace on ce_cpu2x, 0 = pace on ce_cpu
//   dl                  : download bus (slave side)
//   mbc_type .. old_licensee : captured header bytes
//   hdr_chk_ok          : header checksum matches byte 0x14D
//   probe_match         : per-probe logo match
//   dl_size             : highest written address + 2
//   scan_done           : results valid
//   cart_ready          : sticky, set after the first completed write
//
// state  | meaning
// IDLE   | no download seen since reset
// LOAD   | image downloading, scanning writes
// FINAL  | download ended, latch checksum and probe results
// DONE   | results valid, waiting for a new download
module cart_header_scan
   import cart_hdr_pkg::*;
#(
   parameter int ADDR_W      = 25,
   parameter int NUM_PROBES  = 4,
   parameter int PROBE_SHIFT = 18,
   parameter int LOGO_WORDS  = 8
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  ce_cpu,
   input  logic                  ce_cpu2x,
   input  logic                  speed,
   cart_header_scan_if.slave     dl,
   output logic                  cart_ready,
   output logic [7:0]            mbc_type,
   output logic [7:0]            rom_size,
   output logic [7:0]            ram_size,
   output logic [7:0]            cgb_flag,
   output logic [7:0]            sgb_flag,
   output logic [7:0]            old_licensee,
   output logic                  hdr_chk_ok,
   output logic [NUM_PROBES-1:0] probe_match,
   output logic [ADDR_W-1:0]     dl_size,
   output logic                  scan_done
);

   localparam int IDX_W = (LOGO_WORDS > 1) ? $clog2(LOGO_WORDS) : 1;
   localparam logic [11:0] LOGO_END = OFS_LOGO + 12'(2 * (LOGO_WORDS - 1));

   scan_state_e state, state_nx;
   logic        dl_prev;
   logic        dl_rise, dl_fall;
   logic        scan_clear, scan_latch, scan_act;

   logic [11:0]       ofs;
   logic              hdr_page;
   logic [ADDR_W-1:0] addr_p2;
   logic [IDX_W-1:0]  logo_idx;
   logic [7:0]        chk_sum;
   logic [7:0]        chk_exp;
   logic [LOGO_WORDS-1:0][15:0] logo_ref;

   logic tick;
   logic ioctl_wait_q, dn_write_q;

   assign dl_rise = dl.cart_download && !dl_prev;
   assign dl_fall = !dl.cart_download && dl_prev;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         dl_prev <= 1'b0;
      end else begin
         state   <= state_nx;
         dl_prev <= dl.cart_download;
      end
   end

   always_comb begin
      state_nx   = state;
      scan_clear = 1'b0;
      scan_latch = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (dl_rise) begin
               state_nx   = ST_LOAD;
               scan_clear = 1'b1;
            end
         end
         ST_LOAD: begin
            if (dl_rise) begin
               scan_clear = 1'b1;
            end else if (dl_fall) begin
               state_nx = ST_FINAL;
            end
         end
         ST_FINAL: begin
            scan_latch = 1'b1;
            state_nx   = ST_DONE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign scan_act = (state == ST_LOAD) && dl.ioctl_wr;
   assign hdr_page = (dl.ioctl_addr[ADDR_W-1:12] == '0);
   assign ofs      = dl.ioctl_addr[11:0];
   assign addr_p2  = dl.ioctl_addr + ADDR_W'(2);
   assign logo_idx = IDX_W'((ofs - OFS_LOGO) >> 1);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         cgb_flag     <= '0;
         sgb_flag     <= '0;
         mbc_type     <= '0;
         rom_size     <= '0;
         ram_size     <= '0;
         old_licensee <= '0;
         chk_sum      <= '0;
         chk_exp      <= '0;
         dl_size      <= '0;
      end else if (scan_clear) begin
         cgb_flag     <= '0;
         sgb_flag     <= '0;
         mbc_type     <= '0;
         rom_size     <= '0;
         ram_size     <= '0;
         old_licensee <= '0;
         chk_sum      <= '0;
         chk_exp      <= '0;
         dl_size      <= '0;
      end else if (scan_act) begin
         if (hdr_page) begin
            case (ofs)
               OFS_CGB:     cgb_flag <= dl.ioctl_dout[15:8];
               OFS_SGB_MBC: {mbc_type, sgb_flag} <= dl.ioctl_dout;
               OFS_ROM_RAM: {ram_size, rom_size} <= dl.ioctl_dout;
               OFS_LIC:     old_licensee <= dl.ioctl_dout[15:8];
               default: ;
            endcase
            if (ofs >= OFS_CHK_LO && ofs <= OFS_LIC) begin
               chk_sum <= chk_sum + dl.ioctl_dout[7:0] + dl.ioctl_dout[15:8];
            end else if (ofs == OFS_CHK_HI) begin
               // 0x14C is the last summed byte; 0x14D holds the expected value
               chk_sum <= chk_sum + dl.ioctl_dout[7:0];
               chk_exp <= dl.ioctl_dout[15:8];
            end
         end
         if (addr_p2 > dl_size) dl_size <= addr_p2;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         logo_ref <= '0;
      end else if (scan_act && hdr_page && ofs >= OFS_LOGO && ofs <= LOGO_END) begin
         logo_ref[logo_idx] <= dl.ioctl_dout;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         hdr_chk_ok <= 1'b0;
         scan_done  <= 1'b0;
      end else if (scan_clear) begin
         hdr_chk_ok <= 1'b0;
         scan_done  <= 1'b0;
      end else if (scan_latch) begin
         hdr_chk_ok <= (hdr_chk_calc(chk_sum) == chk_exp);
         scan_done  <= 1'b1;
      end
   end

   for (genvar k = 0; k < NUM_PROBES; k++) begin : g_probe
      cart_logo_probe #(
         .ADDR_W     (ADDR_W),
         .LOGO_WORDS (LOGO_WORDS),
         .BASE       (ADDR_W'((k + 1) << PROBE_SHIFT))
      ) u_probe (
         .clk_sys  (clk_sys),
         .reset    (reset),
         .clear    (scan_clear),
         .latch    (scan_latch),
         .wr_en    (scan_act),
         .addr     (dl.ioctl_addr),
         .dout     (dl.ioctl_dout),
         .logo_ref (logo_ref),
         .match    (probe_match[k])
      );
   end

   // Handshake: a strobe raises ioctl_wait; the next tick issues dn_write,
   // the tick after that retires it. A strobe landing on the retiring tick
   // keeps ioctl_wait high so the new word gets its own pulse.
   assign tick = speed ? ce_cpu2x : ce_cpu;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         ioctl_wait_q <= 1'b0;
         dn_write_q   <= 1'b0;
         cart_ready   <= 1'b0;
      end else begin
         if (tick) begin
            if (dn_write_q) begin
               dn_write_q   <= 1'b0;
               ioctl_wait_q <= 1'b0;
               cart_ready   <= 1'b1;
            end else begin
               dn_write_q <= ioctl_wait_q;
            end
         end
         if (dl.ioctl_wr) ioctl_wait_q <= 1'b1;
      end
   end

   assign dl.ioctl_wait = ioctl_wait_q;
   assign dl.dn_write   = dn_write_q;

endmodule

// File: tb/tb_cart_header_scan.sv
module tb_cart_header_scan;

   localparam int ADDR_W = 25;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ce_cpu = 1'b0;
   logic        ce_cpu2x = 1'b0;
   logic        speed = 1'b0;
   logic        cart_ready;
   logic [7:0]  mbc_type, rom_size, ram_size, cgb_flag, sgb_flag, old_licensee;
   logic        hdr_chk_ok;
   logic [3:0]  probe_match;
   logic [ADDR_W-1:0] dl_size;
   logic        scan_done;

   int checks = 0;
   int failures = 0;
   int unsigned ce_cnt = 0;

   logic [15:0] logo_tab [8] = '{16'hEDCE, 16'h6666, 16'h0DCC, 16'h0B00,
                                 16'h7303, 16'h8300, 16'h0C00, 16'h0D00};

   cart_header_scan_if #(.ADDR_W(ADDR_W)) dl();

   cart_header_scan #(
      .ADDR_W(ADDR_W), .NUM_PROBES(4), .PROBE_SHIFT(18), .LOGO_WORDS(8)
   ) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .ce_cpu       (ce_cpu),
      .ce_cpu2x     (ce_cpu2x),
      .speed        (speed),
      .dl           (dl),
      .cart_ready   (cart_ready),
      .mbc_type     (mbc_type),
      .rom_size     (rom_size),
      .ram_size     (ram_size),
      .cgb_flag     (cgb_flag),
      .sgb_flag     (sgb_flag),
      .old_licensee (old_licensee),
      .hdr_chk_ok   (hdr_chk_ok),
      .probe_match  (probe_match),
      .dl_size      (dl_size),
      .scan_done    (scan_done)
   );

   always #5 clk_sys = ~clk_sys;

   // ce_cpu every 4th cycle, ce_cpu2x every 2nd, updated just after posedge
   initial begin
      forever begin
         @(posedge clk_sys);
         #1;
         ce_cnt++;
         ce_cpu   = (ce_cnt % 4 == 0);
         ce_cpu2x = (ce_cnt % 2 == 0);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] hdr_word(input int a, input logic [15:0] cw);
      case (a)
         'h134:   return 16'h4F54;
         'h142:   return 16'h8000;
         'h146:   return 16'h0100;
         'h148:   return 16'h0204;
         'h14A:   return 16'h3300;
         'h14C:   return cw;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic do_wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
      int n;
      @(negedge clk_sys);
      dl.ioctl_addr = a;
      dl.ioctl_dout = d;
      dl.ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      dl.ioctl_wr = 1'b0;
      n = 0;
      while (dl.ioctl_wait && n < 40) begin
         @(negedge clk_sys);
         n++;
      end
      if (n >= 40) chk("wr_wait_timeout", 32'(dl.ioctl_wait), 32'h0);
   endtask

   task automatic load_image(input int size, input logic [15:0] chk_word,
                             input int bad_probe, input int bad_word);
      int n;
      int base;
      logic [15:0] d;
      @(negedge clk_sys);
      dl.cart_download = 1'b1;
      @(negedge clk_sys);
      for (int i = 0; i < 8; i++) do_wr(ADDR_W'('h104 + 2 * i), logo_tab[i]);
      for (int a = 'h134; a <= 'h14C; a += 2) do_wr(ADDR_W'(a), hdr_word(a, chk_word));
      for (int k = 0; k < 4; k++) begin
         base = (k + 1) << 18;
         if (base + 'h200 <= size) begin
            for (int i = 0; i < 8; i++) begin
               d = logo_tab[i] ^ ((k == bad_probe && i == bad_word) ? 16'h0100 : 16'h0000);
               do_wr(ADDR_W'(base + 'h104 + 2 * i), d);
            end
         end
      end
      do_wr(ADDR_W'(size - 2), 16'h0000);
      @(negedge clk_sys);
      dl.cart_download = 1'b0;
      n = 0;
      while (!scan_done && n < 20) begin
         @(negedge clk_sys);
         n++;
      end
      chk("scan_done", 32'(scan_done), 32'h1);
   endtask

   initial begin
      int n;
      int w;
      dl.cart_download = 1'b0;
      dl.ioctl_wr      = 1'b0;
      dl.ioctl_addr    = '0;
      dl.ioctl_dout    = '0;

      // reset state
      repeat (3) @(negedge clk_sys);
      chk("rst_wait", 32'(dl.ioctl_wait), 32'h0);
      chk("rst_dn_write", 32'(dl.dn_write), 32'h0);
      chk("rst_cart_ready", 32'(cart_ready), 32'h0);
      chk("rst_scan_done", 32'(scan_done), 32'h0);
      chk("rst_dl_size", 32'(dl_size), 32'h0);
      chk("rst_probe", 32'(probe_match), 32'h0);
      reset = 1'b0;

      // handshake at double speed, strobe on the retiring tick
      speed = 1'b1;
      @(negedge clk_sys);
      dl.ioctl_addr = 25'h200;
      dl.ioctl_dout = 16'h1234;
      dl.ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      dl.ioctl_wr = 1'b0;
      chk("hs_wait_set", 32'(dl.ioctl_wait), 32'h1);
      n = 0;
      while (!dl.dn_write && n < 10) begin @(negedge clk_sys); n++; end
      chk("hs_dn_first", 32'(dl.dn_write), 32'h1);
      chk("hs_ready_before", 32'(cart_ready), 32'h0);
      n = 0;
      while (!ce_cpu2x && n < 10) begin @(negedge clk_sys); n++; end
      dl.ioctl_wr = 1'b1;
      @(negedge clk_sys);
      dl.ioctl_wr = 1'b0;
      chk("hs_dn_cleared", 32'(dl.dn_write), 32'h0);
      chk("hs_wait_held", 32'(dl.ioctl_wait), 32'h1);
      chk("hs_ready_set", 32'(cart_ready), 32'h1);
      n = 0;
      while (!dl.dn_write && n < 10) begin @(negedge clk_sys); n++; end
      chk("hs_dn_second", 32'(dl.dn_write), 32'h1);
      w = 0;
      while (dl.dn_write && w < 10) begin @(negedge clk_sys); w++; end
      chk("hs_dn_width", 32'(w), 32'h2);
      chk("hs_wait_done", 32'(dl.ioctl_wait), 32'h0);
      chk("idle_no_dl_size", 32'(dl_size), 32'h0);
      speed = 1'b0;

      // valid 512 KB image
      load_image('h80000, 16'h8901, -1, 0);
      chk("v_mbc", 32'(mbc_type), 32'h01);
      chk("v_rom", 32'(rom_size), 32'h04);
      chk("v_ram", 32'(ram_size), 32'h02);
      chk("v_cgb", 32'(cgb_flag), 32'h80);
      chk("v_sgb", 32'(sgb_flag), 32'h00);
      chk("v_lic", 32'(old_licensee), 32'h33);
      chk("v_chk_ok", 32'(hdr_chk_ok), 32'h1);
      chk("v_probe", 32'(probe_match), 32'h1);
      chk("v_dl_size", 32'(dl_size), 32'h80000);

      // byte 0x14D corrupted
      load_image('h80000, 16'h0001, -1, 0);
      chk("c_chk_ok", 32'(hdr_chk_ok), 32'h0);
      chk("c_mbc", 32'(mbc_type), 32'h01);
      chk("c_lic", 32'(old_licensee), 32'h33);
      chk("c_probe", 32'(probe_match), 32'h1);
      chk("c_dl_size", 32'(dl_size), 32'h80000);

      // 128 KB image, every probe beyond the end
      load_image('h20000, 16'h8901, -1, 0);
      chk("s_probe", 32'(probe_match), 32'h0);
      chk("s_dl_size", 32'(dl_size), 32'h20000);
      chk("s_chk_ok", 32'(hdr_chk_ok), 32'h1);

      // 2 MB image, probe 1 logo word 3 differs
      load_image('h200000, 16'h8901, 1, 3);
      chk("m_probe", 32'(probe_match), 32'hD);
      chk("m_dl_size", 32'(dl_size), 32'h200000);

      // reset in the middle of a download
      @(negedge clk_sys);
      dl.cart_download = 1'b1;
      @(negedge clk_sys);
      for (int a = 'h134; a <= 'h148; a += 2) do_wr(ADDR_W'(a), hdr_word(a, 16'h8901));
      @(negedge clk_sys);
      dl.ioctl_addr = 25'h14A;
      dl.ioctl_dout = 16'h3300;
      dl.ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      dl.ioctl_wr = 1'b0;
      chk("r_pre_mbc", 32'(mbc_type), 32'h01);
      chk("r_pre_wait", 32'(dl.ioctl_wait), 32'h1);
      reset = 1'b1;
      #1;
      chk("r_mbc", 32'(mbc_type), 32'h0);
      chk("r_lic", 32'(old_licensee), 32'h0);
      chk("r_dl_size", 32'(dl_size), 32'h0);
      chk("r_wait", 32'(dl.ioctl_wait), 32'h0);
      chk("r_dn_write", 32'(dl.dn_write), 32'h0);
      chk("r_cart_ready", 32'(cart_ready), 32'h0);
      chk("r_scan_done", 32'(scan_done), 32'h0);
      chk("r_probe", 32'(probe_match), 32'h0);
      chk("r_chk_ok", 32'(hdr_chk_ok), 32'h0);
      dl.cart_download = 1'b0;
      @(negedge clk_sys);
      reset = 1'b0;
      repeat (4) @(negedge clk_sys);
      chk("r_idle_scan_done", 32'(scan_done), 32'h0);

      load_image('h80000, 16'h8901, -1, 0);
      chk("f_mbc", 32'(mbc_type), 32'h01);
      chk("f_chk_ok", 32'(hdr_chk_ok), 32'h1);
      chk("f_probe", 32'(probe_match), 32'h1);
      chk("f_dl_size", 32'(dl_size), 32'h80000);
      chk("f_cart_ready", 32'(cart_ready), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cart_header_scan.md
Name: cart_header_scan

Overview:
- Snoops the ROM download stream (`ioctl_*`) while a cartridge image loads.
- Extracts the header fields, checks the header checksum, and measures the image size.
- Compares the Nintendo logo against NUM_PROBES candidate bank offsets to detect multicarts.
- Paces the download handshake (`ioctl_wait`/`dn_write`) against the CPU clock enable. Sits between the HPS download path and the mapper and SDRAM write logic.

Parameters:
- ADDR_W, 25: width of `ioctl_addr` (byte address; bit 0 is always 0).
- NUM_PROBES, 4: number of logo-probe slots.
- PROBE_SHIFT, 18: probe k base address = (k+1) << PROBE_SHIFT (default 256 KB steps).
- LOGO_WORDS, 8: 16-bit logo words compared, starting at offset 0x104.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ce_cpu  in  1  CPU clock enable.
- ce_cpu2x  in  1  double-speed CPU clock enable.
- speed  in  1  1 = pace on ce_cpu2x, 0 = pace on ce_cpu.
- cart_download  in  1  high while a cartridge image is downloading.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_addr  in  ADDR_W  byte address of the word.
- ioctl_dout  in  16  data word; [7:0] = even byte, [15:8] = odd byte.
- ioctl_wait  out  1  stall request to the HPS.
- dn_write  out  1  one-ce-tick SDRAM write pulse.
- cart_ready  out  1  sticky; set after the first completed write.
- mbc_type  out  8  header byte 0x147.
- rom_size  out  8  header byte 0x148.
- ram_size  out  8  header byte 0x149.
- cgb_flag  out  8  header byte 0x143.
- sgb_flag  out  8  header byte 0x146.
- old_licensee  out  8  header byte 0x14B.
- hdr_chk_ok  out  1  computed header checksum equals byte 0x14D.
- probe_match  out  NUM_PROBES  bit k = logo at probe k equals the bank-0 logo.
- dl_size  out  ADDR_W  highest written address + 2.
- scan_done  out  1  results valid.

Behaviour:
- Reset (async): all outputs 0 and state IDLE. This includes `ioctl_wait`, `dn_write` and `cart_ready`.
- FSM states: IDLE, LOAD, FINAL, DONE.
  - IDLE/DONE -> LOAD on a rising edge of `cart_download`. On entry, clear the header fields, checksum accumulator, `probe_match`, per-probe mismatch and seen counters, `dl_size` and `scan_done`.
  - LOAD -> FINAL on a falling edge of `cart_download`.
  - FINAL -> DONE after one cycle. In FINAL, latch `hdr_chk_ok` and each probe_match[k] = (seen_k == LOGO_WORDS) & ~mismatch_k. `scan_done` rises on entry to DONE.
  - A new rising edge in LOAD or DONE restarts the scan (DONE -> LOAD). `cart_ready` is not cleared by a restart.
- Header capture (LOAD, `ioctl_wr`, `ioctl_addr[ADDR_W-1:12]` == 0): the field register updates on the cycle after the strobe.
  - 0x142 -> cgb_flag = dout[15:8].
  - 0x146 -> {mbc_type, sgb_flag} = dout.
  - 0x148 -> {ram_size, rom_size} = dout.
  - 0x14A -> old_licensee = dout[15:8].
- Checksum:
  - 8-bit accumulator, mod 256.
  - Words 0x134..0x14A: add both bytes.
  - Word 0x14C: add the low byte; capture dout[15:8] as expected.
  - hdr_chk_ok = ((0 - sum - 8'd25) == expected).
- Logo:
  - Bank-0 words 0x104..0x104+2*(LOGO_WORDS-1) are stored in an array; index = (addr - 0x104) >> 1, derived from the address, with no running counter.
  - A write at probe k base + the same offset compares against the stored word, increments seen_k, and sets mismatch_k on inequality.
  - A probe whose base lies beyond the image never fills seen_k, so its match bit stays 0.
  - Probe bases aliasing bank 0 are not permitted (k+1 >= 1 guarantees this).
- dl_size: on each `ioctl_wr`, dl_size = max(dl_size, ioctl_addr + 2). Writes are monotonic.
- Handshake:
  - `ioctl_wr` sets `ioctl_wait` next cycle.
  - On each tick (tick = speed ? ce_cpu2x : ce_cpu): dn_write <= ioctl_wait.
  - If `dn_write` was already 1 on that tick, clear both `dn_write` and `ioctl_wait`, and set `cart_ready`.
  - `dn_write` therefore lasts exactly one tick period.
  - If `ioctl_wr` coincides with the clearing tick, the set wins and `ioctl_wait` stays 1.
- Handshake is active in every state.
- Header capture, checksum, logo, probe and dl_size updates happen only in LOAD.
- Reset mid-LOAD: state and results are lost, and `scan_done` stays 0 until a complete download.

Decomposition:
- Package `cart_hdr_pkg` holds:
  - header offset constants (0x104, 0x134, 0x142, 0x146, 0x148, 0x14A, 0x14C);
  - the checksum bias 8'd25;
  - the FSM state enum.
- One sub-module, `cart_logo_probe`: a single probe slot holding the seen counter, mismatch flag and match output. It is instantiated NUM_PROBES times via generate.

Test Plan:
- Valid 512 KB image; bank 0 logo equals the logo at 0x40000; header sum correct. Expected: mbc_type = 0x01, hdr_chk_ok = 1, probe_match = 4'b0001, dl_size = 0x80000, scan_done = 1.
- Same image with byte 0x14D corrupted to 0x00. Expected: hdr_chk_ok = 0, all other fields unchanged.
- 128 KB image (probes beyond the end). Expected: probe_match = 0, dl_size = 0x20000.
- Logo word 3 at probe 1 (0x80104+6) differs. Expected: probe_match[1] = 0 while the other full probes match.
- speed = 1 with ce_cpu2x every 2 cycles, and `ioctl_wr` issued on the clearing tick. Expected: `ioctl_wait` stays 1, a second `dn_write` pulse follows, and `cart_ready` = 1 after the first pulse.
- Assert reset mid-LOAD, then run a fresh download. Expected: all outputs 0 immediately, and correct results after the new download.
